scp_inst_encoder: RTL and testbench

Instruction encoder and loader for the single-cycle processor (SCP). It accepts instructions as decoded fields (kind, func, register indices, immediate) over a valid/ready stream and packs each into the 32-bit SCP instruction word. It then writes the words to consecutive instruction-memory addresses from a programmable base. It sits between the test/boot loader and the instruction-memory write port, and produces exactly the words the processor controller decodes.

---
 rtl/scp_isa_pkg.sv | 37 +++
 rtl/scp_inst_encoder_if.sv | 24 ++
 rtl/scp_inst_pack.sv | 61 ++++++
 rtl/scp_inst_encoder.sv | 98 +++++++++
 tb/tb_scp_inst_encoder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scp_isa_pkg.sv
// rtl/scp_isa_pkg.sv - SCP instruction-set constants shared by the encoder and processor controller
package scp_isa_pkg;

   localparam logic [3:0] OP_ALU_R  = 4'b0000;
   localparam logic [3:0] OP_ALU_I  = 4'b1000;
   localparam logic [3:0] OP_LOAD   = 4'b1001;
   localparam logic [3:0] OP_STORE  = 4'b0101;
   localparam logic [3:0] OP_CMP_R  = 4'b0010;
   localparam logic [3:0] OP_CMP_I  = 4'b1010;
   localparam logic [3:0] OP_BRANCH = 4'b0110;
   localparam logic [3:0] OP_JAL    = 4'b1011;

   typedef enum logic [3:0] {
      KIND_ALU_R  = 4'd0,
      KIND_ALU_I  = 4'd1,
      KIND_LOAD   = 4'd2,
      KIND_STORE  = 4'd3,
      KIND_CMP_R  = 4'd4,
      KIND_CMP_I  = 4'd5,
      KIND_BRANCH = 4'd6,
      KIND_JAL    = 4'd7
   } kind_t;

   // Low bit of each field; nibble fields are 4 wide, imm is 16 wide.
   localparam int RD_LSB   = 28;
   localparam int RS1_LSB  = 24;
   localparam int RS2_LSB  = 20;
   localparam int IMM_LSB  = 8;
   localparam int FUNC_LSB = 4;
   localparam int OP_LSB   = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/scp_inst_encoder_if.sv
// rtl/scp_inst_encoder_if.sv - decoded-instruction request stream into the encoder
interface scp_inst_encoder_if;

   logic        reqValid;
   logic        reqReady;
   logic [3:0]  reqKind;
   logic [3:0]  reqFunc;
   logic [3:0]  reqRd;
   logic [3:0]  reqRs1;
   logic [3:0]  reqRs2;
   logic [15:0] reqImm;
   logic        reqLast;

   modport master (
      output reqValid, reqKind, reqFunc, reqRd, reqRs1, reqRs2, reqImm, reqLast,
      input  reqReady
   );

   modport slave (
      input  reqValid, reqKind, reqFunc, reqRd, reqRs1, reqRs2, reqImm, reqLast,
      output reqReady
   );

endinterface

// File: rtl/scp_inst_pack.sv
// rtl/scp_inst_pack.sv - combinational packer from decoded fields to a 32-bit SCP word
module scp_inst_pack
   import scp_isa_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [3:0]  func,
   input  logic [3:0]  rd,
   input  logic [3:0]  rs1,
   input  logic [3:0]  rs2,
   input  logic [15:0] imm,
   output logic [31:0] word,
   output logic        legal
);

   typedef enum logic [1:0] {FMT_RRR, FMT_RRI, FMT_SSI} fmt_t;

   fmt_t       fmt;
   logic [3:0] opcode;

   always_comb begin
      fmt    = FMT_RRR;
      opcode = OP_ALU_R;
      legal  = 1'b1;
      case (kind)
         KIND_ALU_R:  begin fmt = FMT_RRR; opcode = OP_ALU_R;  end
         KIND_ALU_I:  begin fmt = FMT_RRI; opcode = OP_ALU_I;  end
         KIND_LOAD:   begin fmt = FMT_RRI; opcode = OP_LOAD;   end
         KIND_STORE:  begin fmt = FMT_SSI; opcode = OP_STORE;  end
         KIND_CMP_R:  begin fmt = FMT_RRR; opcode = OP_CMP_R;  end
         KIND_CMP_I:  begin fmt = FMT_RRI; opcode = OP_CMP_I;  end
         KIND_BRANCH: begin fmt = FMT_SSI; opcode = OP_BRANCH; end
         KIND_JAL:    begin fmt = FMT_RRI; opcode = OP_JAL;    end
         default:     legal = 1'b0;
      endcase
   end

   // Store/branch put the base and data operands in the top two nibbles instead of rd/rs1.
   always_comb begin
      word = '0;
      word[FUNC_LSB +: 4] = func;
      word[OP_LSB +: 4]   = opcode;
      case (fmt)
         FMT_RRR: begin
            word[RD_LSB +: 4]  = rd;
            word[RS1_LSB +: 4] = rs1;
            word[RS2_LSB +: 4] = rs2;
         end
         FMT_RRI: begin
            word[RD_LSB +: 4]   = rd;
            word[RS1_LSB +: 4]  = rs1;
            word[IMM_LSB +: 16] = imm;
         end
         default: begin
            word[RD_LSB +: 4]   = rs1;
            word[RS1_LSB +: 4]  = rs2;
            word[IMM_LSB +: 16] = imm;
         end
      endcase
   end

endmodule

// File: rtl/scp_inst_encoder.sv
// rtl/scp_inst_encoder.sv - encodes request fields and loads words into instruction memory
module scp_inst_encoder
   import scp_isa_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   baseAddr,
   scp_inst_encoder_if.slave   req,
   output logic                imemWrEn,
   output logic [ADDR_W-1:0]   imemAddr,
   output logic [31:0]         imemData,
   output logic                busy,
   output logic                done,
   output logic                errIllegal,
   output logic                errOverflow,
   output logic [ADDR_W:0]     wordCount
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_cnt;
   logic [31:0]       packed_word;
   logic              packed_legal;
   logic              accept;
   logic              at_top;
   logic              overflow;
   logic              session_end;

   scp_inst_pack u_pack (
      .kind  (req.reqKind),
      .func  (req.reqFunc),
      .rd    (req.reqRd),
      .rs1   (req.reqRs1),
      .rs2   (req.reqRs2),
      .imm   (req.reqImm),
      .word  (packed_word),
      .legal (packed_legal)
   );

   assign req.reqReady = (state == S_RUN);
   assign busy         = (state != S_IDLE);
   assign accept       = req.reqValid && req.reqReady;
   assign at_top       = (addr_cnt == {ADDR_W{1'b1}});
   // A legal non-last word at the top address ends the session so the counter never wraps into a write.
   assign overflow     = accept && packed_legal && at_top && !req.reqLast;
   assign session_end  = (accept && req.reqLast) || overflow;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN:  if (session_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_cnt    <= '0;
         imemWrEn    <= 1'b0;
         imemAddr    <= '0;
         imemData    <= '0;
         done        <= 1'b0;
         errIllegal  <= 1'b0;
         errOverflow <= 1'b0;
         wordCount   <= '0;
      end else begin
         imemWrEn <= 1'b0;
         done     <= session_end;
         if (state == S_IDLE && start) begin
            addr_cnt    <= baseAddr;
            wordCount   <= '0;
            errIllegal  <= 1'b0;
            errOverflow <= 1'b0;
         end
         if (accept) begin
            if (packed_legal) begin
               imemWrEn  <= 1'b1;
               imemAddr  <= addr_cnt;
               imemData  <= packed_word;
               addr_cnt  <= addr_cnt + ADDR_W'(1);
               wordCount <= wordCount + (ADDR_W+1)'(1);
            end else begin
               errIllegal <= 1'b1;
            end
         end
         if (overflow) errOverflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_scp_inst_encoder.sv
// tb/tb_scp_inst_encoder.sv - randomized self-checking bench for scp_inst_encoder
module tb_scp_inst_encoder;

   localparam int ADDR_W = 10;
   localparam int TOP    = (1 << ADDR_W) - 1;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] baseAddr = '0;
   logic              imemWrEn;
   logic [ADDR_W-1:0] imemAddr;
   logic [31:0]       imemData;
   logic              busy;
   logic              done;
   logic              errIllegal;
   logic              errOverflow;
   logic [ADDR_W:0]   wordCount;

   scp_inst_encoder_if bus ();

   scp_inst_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .baseAddr    (baseAddr),
      .req         (bus.slave),
      .imemWrEn    (imemWrEn),
      .imemAddr    (imemAddr),
      .imemData    (imemData),
      .busy        (busy),
      .done        (done),
      .errIllegal  (errIllegal),
      .errOverflow (errOverflow),
      .wordCount   (wordCount)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: session flag, next address, words written, sticky errors.
   bit m_run = 0;
   int m_addr = 0;
   int m_cnt = 0;
   bit m_ill = 0;
   bit m_ovf = 0;
   bit m_acc = 0;
   int last_wr_addr = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int kind, input int func, input int rd,
                                       input int rs1, input int rs2, input int imm);
      int      opc [8] = '{0, 8, 9, 5, 2, 10, 6, 11};
      longint  w;
      case (kind)
         0, 4:    w = rd * 2**28 + rs1 * 2**24 + rs2 * 2**20;
         3, 6:    w = rs1 * 2**28 + rs2 * 2**24 + imm * 256;
         default: w = rd * 2**28 + rs1 * 2**24 + imm * 256;
      endcase
      w = w + func * 16 + opc[kind];
      return w[31:0];
   endfunction

   task automatic model_reset();
      m_run = 0; m_addr = 0; m_cnt = 0; m_ill = 0; m_ovf = 0; m_acc = 0;
   endtask

   // Apply current inputs for one clock and check everything the DUT shows afterwards.
   task automatic step();
      bit          wr = 0, dn = 0, run_n;
      int          wa = 0;
      logic [31:0] wd = '0;
      run_n = m_run;
      m_acc = 0;
      if (!m_run) begin
         if (start) begin
            run_n = 1; m_addr = int'(baseAddr); m_cnt = 0; m_ill = 0; m_ovf = 0;
         end
      end else if (bus.reqValid) begin
         m_acc = 1;
         if (bus.reqKind < 8) begin
            wr = 1; wa = m_addr;
            wd = enc(bus.reqKind, bus.reqFunc, bus.reqRd, bus.reqRs1, bus.reqRs2, bus.reqImm);
            m_cnt++;
            if (m_addr == TOP && !bus.reqLast) begin
               m_ovf = 1; dn = 1; run_n = 0;
            end
            m_addr = (m_addr + 1) % (TOP + 1);
         end else begin
            m_ill = 1;
         end
         if (bus.reqLast) begin dn = 1; run_n = 0; end
      end
      m_run = run_n;
      @(posedge clk); #1;
      check("reqReady", 32'(bus.reqReady), 32'(m_run));
      check("busy", 32'(busy), 32'(m_run));
      check("imemWrEn", 32'(imemWrEn), 32'(wr));
      if (wr) begin
         check("imemAddr", 32'(imemAddr), 32'(wa));
         check("imemData", imemData, wd);
         if (last_wr_addr >= 0) check("addr_consecutive", 32'(imemAddr), 32'((last_wr_addr + 1) % (TOP + 1)));
         last_wr_addr = int'(imemAddr);
      end
      check("done", 32'(done), 32'(dn));
      check("errIllegal", 32'(errIllegal), 32'(m_ill));
      check("errOverflow", 32'(errOverflow), 32'(m_ovf));
      check("wordCount", 32'(wordCount), 32'(m_cnt));
   endtask

   task automatic begin_session(input int base);
      start = 1; baseAddr = ADDR_W'(base);
      step();
      start = 0;
      last_wr_addr = -1;
   endtask

   task automatic send(input int kind, input int func, input int rd, input int rs1,
                       input int rs2, input int imm, input bit last);
      int n = 0;
      bus.reqValid = 1; bus.reqKind = 4'(kind); bus.reqFunc = 4'(func);
      bus.reqRd = 4'(rd); bus.reqRs1 = 4'(rs1); bus.reqRs2 = 4'(rs2);
      bus.reqImm = 16'(imm); bus.reqLast = last;
      do begin
         step();
         n++;
      end while (!m_acc && n < 20);
      if (!m_acc) check("send_timeout", 32'd0, 32'd1);
      bus.reqValid = 0; bus.reqLast = 0;
   endtask

   task automatic check_reset_outputs();
      check("rst_imemWrEn", 32'(imemWrEn), 32'd0);
      check("rst_imemAddr", 32'(imemAddr), 32'd0);
      check("rst_imemData", imemData, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_errIllegal", 32'(errIllegal), 32'd0);
      check("rst_errOverflow", 32'(errOverflow), 32'd0);
      check("rst_wordCount", 32'(wordCount), 32'd0);
      check("rst_reqReady", 32'(bus.reqReady), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int acc_words, guard;
      bus.reqValid = 0; bus.reqKind = 0; bus.reqFunc = 0; bus.reqRd = 0;
      bus.reqRs1 = 0; bus.reqRs2 = 0; bus.reqImm = 0; bus.reqLast = 0;
      #2;
      check_reset_outputs();
      @(posedge clk); #1;
      reset_n = 1;
      step();

      // Directed two-word session.
      begin_session('h010);
      send(0, 2, 3, 1, 2, 0, 0);
      check("first_word", imemData, 32'h31200020);
      send(1, 0, 5, 0, 0, 'hFFFF, 1);
      check("second_word", imemData, 32'h50FFFF08);
      check("second_addr", 32'(imemAddr), 32'h011);
      check("second_done", 32'(done), 32'd1);
      check("second_count", 32'(wordCount), 32'd2);

      // Operand-layout encodings.
      begin_session('h100);
      send(3, 0, 9, 2, 7, 4, 0);
      check("enc_store", imemData, 32'h27000405);
      send(6, 1, 9, 1, 2, 3, 0);
      check("enc_branch", imemData, 32'h12000316);
      send(7, 0, 15, 4, 0, 'h10, 1);
      check("enc_jal", imemData, 32'hF400100B);

      // Illegal kind between legal words, then illegal kind as the last request.
      begin_session('h020);
      send(4, 3, 1, 2, 3, 0, 0);
      send(9, 0, 0, 0, 0, 0, 0);
      send(5, 1, 4, 5, 6, 'h1234, 0);
      check("illegal_adjacent", 32'(imemAddr), 32'h021);
      send(12, 0, 0, 0, 0, 0, 1);
      check("illegal_last_done", 32'(done), 32'd1);
      check("illegal_sticky", 32'(errIllegal), 32'd1);
      check("illegal_count", 32'(wordCount), 32'd2);

      // Overflow at the top of memory.
      begin_session('h3FE);
      send(0, 0, 1, 1, 1, 0, 0);
      send(0, 0, 2, 2, 2, 0, 0);
      check("ovf_flag", 32'(errOverflow), 32'd1);
      check("ovf_done", 32'(done), 32'd1);
      bus.reqValid = 1; bus.reqKind = 0; bus.reqLast = 0;
      repeat (3) step();
      bus.reqValid = 0;
      check("ovf_count", 32'(wordCount), 32'd2);

      // Reset in the middle of a session with a request pending.
      begin_session('h200);
      send(2, 0, 1, 2, 0, 'h55, 0);
      bus.reqValid = 1; bus.reqKind = 1;
      #3 reset_n = 0;
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clk); #1;
      reset_n = 1;
      repeat (4) step();
      bus.reqValid = 0;

      // Random valid toggling over a 20-word session with random legal contents.
      begin_session($urandom_range(0, 900));
      acc_words = 0;
      guard = 0;
      while (acc_words < 20 && guard < 400) begin
         bus.reqValid = 1'($urandom_range(0, 1));
         bus.reqKind = 4'($urandom_range(0, 7));
         bus.reqFunc = 4'($urandom); bus.reqRd = 4'($urandom);
         bus.reqRs1 = 4'($urandom); bus.reqRs2 = 4'($urandom);
         bus.reqImm = 16'($urandom);
         bus.reqLast = (acc_words == 19);
         step();
         if (m_acc) acc_words++;
         guard++;
      end
      bus.reqValid = 0; bus.reqLast = 0;
      if (acc_words < 20) check("random_timeout", 32'(acc_words), 32'd20);
      check("random_count", 32'(wordCount), 32'd20);

      // Random sessions mixing illegal kinds; start pulses during RUN must be ignored.
      repeat (3) begin
         begin_session($urandom_range(0, TOP));
         guard = 0;
         while (m_run && guard < 60) begin
            bus.reqValid = 1'($urandom_range(0, 1));
            bus.reqKind = 4'($urandom);
            bus.reqFunc = 4'($urandom); bus.reqRd = 4'($urandom);
            bus.reqRs1 = 4'($urandom); bus.reqRs2 = 4'($urandom);
            bus.reqImm = 16'($urandom);
            bus.reqLast = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 7) == 0);
            baseAddr = ADDR_W'($urandom);
            step();
            guard++;
         end
         start = 0; bus.reqValid = 0; bus.reqLast = 0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
